rd_lane_dispatch: RTL and testbench
===================================

# rd_lane_dispatch

Read-domain dispatcher between the async FIFO read port and N downstream consumers. It pulls words out of the FIFO into a small local buffer and hands each one to exactly one consumer over a per-lane valid/ready handshake. Consumer selection is round-robin and skips lanes that are not ready. Everything runs on i_rd_clk; the block decouples consumer back-pressure from the FIFO pop timing.

## Interface
- WIDTH, 8, word width in bits.
- N_READERS, 2, number of consumer lanes (≥1).
- BUF_DEPTH, 4, local buffer entries (power of two, ≥2).
- i_rd_clk  in  1  read-domain clock.
- i_rd_rstn  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous clear of buffer, output stage and RR pointer.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_valid  in  1  FIFO data qualifier, same cycle as o_fifo_rd_en.
- i_fifo_data  in  WIDTH  FIFO read data, same cycle as o_fifo_rd_en.
- o_fifo_rd_en  out  1  pop request to the FIFO.
- o_lane_vld  out  N_READERS  one-hot valid, at most one bit set.
- o_lane_data  out  WIDTH  shared data bus, meaningful for the lane with vld set.
- i_lane_rdy  in  N_READERS  per-lane ready.
- o_level  out  $clog2(BUF_DEPTH)+1  buffer occupancy, 0..BUF_DEPTH.
- o_xfer_cnt  out  32  completed transfer count (see Configuration).
- o_stall_cnt  out  32  cycles with vld set and target not ready (see Configuration).

## Operation
- Accept: a FIFO word is taken when o_fifo_rd_en && i_fifo_valid.
- o_fifo_rd_en = !i_fifo_empty && (o_level < BUF_DEPTH) && !i_flush. It uses the registered o_level. It is forced to 0 while reset is asserted.
- Output stage is a single register holding o_lane_data and a target lane index tgt. The stage is free when o_lane_vld==0, or when o_lane_vld[tgt] && i_lane_rdy[tgt] (the transfer completes that cycle).
- Load on free:
  - If the buffer is non-empty, load the buffer head and pop it.
  - Else, if a word is accepted this cycle, load it directly (bypass; it is not written to the buffer).
  - Else, clear o_lane_vld.
- Buffer write: an accepted word is written to the buffer when it does not bypass. Push and pop in the same cycle leave o_level unchanged. Read and write pointers wrap modulo BUF_DEPTH.
- Target selection at load: the first lane at or after rr_ptr (modulo N_READERS) with i_lane_rdy=1. If no lane is ready, tgt = rr_ptr.
- rr_ptr becomes (tgt+1) mod N_READERS on every completed transfer.
- Once o_lane_vld[tgt] is asserted, tgt and o_lane_data hold until that lane's transfer completes. The valid is never withdrawn and never retargeted.
- Ordering: words leave in FIFO order. Each word is delivered exactly once.
- i_flush: next cycle o_lane_vld=0, o_level=0, rr_ptr=0 and the buffer is emptied. No pop occurs in the flush cycle. A transfer completing in the flush cycle still counts as delivered.

## Timing
- Reset values: o_lane_vld=0, o_lane_data=0, o_level=0, rr_ptr=0, o_fifo_rd_en=0, o_xfer_cnt=0, o_stall_cnt=0.
- Latency: a word accepted at cycle t with the buffer empty and the stage free gives o_lane_vld at t+1.
- Throughput: one transfer per cycle when any lane is continuously ready and the FIFO is not empty.
- Buffer full (o_level==BUF_DEPTH): no pop that cycle. Popping resumes the cycle after o_level drops.
- Reset asserted mid-transfer: all state clears immediately. A word held in the stage or buffer is lost. The FIFO is responsible for its own pointers.

## Configuration
- RD_DISPATCH_PERF_EN defined:
  - o_xfer_cnt increments on each completed transfer.
  - o_stall_cnt increments each cycle where |o_lane_vld && !i_lane_rdy[tgt].
  - Both are 32-bit, wrap at 2^32, and clear on reset and i_flush.
- Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Single word 0xA5, buffer empty, lane0 ready, pop at t: o_lane_vld=2'b01 and o_lane_data=0xA5 at t+1. o_level stays 0.
- Words 0x01..0x06 with both lanes always ready: they alternate lane0, lane1, lane0... one per cycle, in order, and o_xfer_cnt=6.
- Both lanes not ready, FIFO holds 8 words: o_level reaches 4 and o_fifo_rd_en drops to 0. One word is held on lane rr_ptr with vld stable. o_stall_cnt increments every cycle.
- Lane0 never ready, lane1 ready, RR pointer at lane0: every word goes to lane1 and no word is lost.
- i_flush with o_level=3 and vld set: next cycle o_level=0, o_lane_vld=0, rr_ptr=0, and no pop in the flush cycle.
- i_rd_rstn pulsed low mid-stream: all outputs at reset values asynchronously. Delivery restarts correctly after release.

Source files
------------

// File: rtl/rd_lane_dispatch.sv
// rtl/rd_lane_dispatch.sv - read-domain FIFO-to-lane round-robin dispatcher
//
// Pops words from the async FIFO read port into a small local buffer and hands
// each word to exactly one consumer lane over a valid/ready handshake. Lane
// choice is round-robin, skipping lanes that are not ready at load time.
//
// Optional feature macro: RD_DISPATCH_PERF_EN (transfer/stall counters).
//
// Ports:
//   i_rd_clk, i_rd_rstn  clock, asynchronous active-low reset
//   i_flush              synchronous clear of buffer, output stage, RR pointer
//   i_fifo_*/o_fifo_rd_en FIFO read port (data/valid same cycle as rd_en)
//   o_lane_vld/o_lane_data/i_lane_rdy  one-hot lane handshake, shared data bus
//   o_level              local buffer occupancy 0..BUF_DEPTH
//   o_xfer_cnt/o_stall_cnt  performance counters (zero when feature is off)
module rd_lane_dispatch #(
    parameter int WIDTH     = 8,
    parameter int N_READERS = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                        i_rd_clk,
    input  logic                        i_rd_rstn,
    input  logic                        i_flush,
    input  logic                        i_fifo_empty,
    input  logic                        i_fifo_valid,
    input  logic [WIDTH-1:0]            i_fifo_data,
    output logic                        o_fifo_rd_en,
    output logic [N_READERS-1:0]        o_lane_vld,
    output logic [WIDTH-1:0]            o_lane_data,
    input  logic [N_READERS-1:0]        i_lane_rdy,
    output logic [$clog2(BUF_DEPTH):0]  o_level,
    output logic [31:0]                 o_xfer_cnt,
    output logic [31:0]                 o_stall_cnt
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TGT_W = (N_READERS > 1) ? $clog2(N_READERS) : 1;

    logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [N_READERS-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [TGT_W-1:0]     tgt_q, tgt_d, rr_q, rr_d, rr_eff, sel;
    logic                 vld_any, xfer, stage_free, accept, push, pop, found;

    // Gated by reset so the FIFO never sees a pop while this block is held.
    assign o_fifo_rd_en = i_rd_rstn && !i_fifo_empty && !i_flush
                        && (level_q < LVL_W'(BUF_DEPTH));
    assign accept     = o_fifo_rd_en && i_fifo_valid;
    assign vld_any    = |vld_q;
    assign xfer       = vld_any && i_lane_rdy[tgt_q];
    assign stage_free = !vld_any || xfer;

    // A transfer completing this cycle advances the pointer before the next
    // load picks its lane, so back-to-back words rotate across lanes.
    assign rr_eff = !xfer ? rr_q :
                    (tgt_q == TGT_W'(N_READERS - 1)) ? '0 : tgt_q + TGT_W'(1);

    always_comb begin
        sel   = rr_eff;
        found = 1'b0;
        for (int i = 0; i < N_READERS; i++) begin
            int idx;
            idx = int'(rr_eff) + i;
            if (idx >= N_READERS) idx = idx - N_READERS;
            if (!found && i_lane_rdy[idx]) begin
                sel   = TGT_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        data_d   = data_q;
        tgt_d    = tgt_q;
        rr_d     = xfer ? rr_eff : rr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        pop      = 1'b0;
        push     = 1'b0;

        if (stage_free) begin
            if (level_q != '0) begin
                pop    = 1'b1;
                data_d = mem_q[rd_ptr_q];
                tgt_d  = sel;
                vld_d  = '0;
                vld_d[sel] = 1'b1;
            end else if (accept) begin
                data_d = i_fifo_data;
                tgt_d  = sel;
                vld_d  = '0;
                vld_d[sel] = 1'b1;
            end else begin
                vld_d = '0;
            end
        end

        // Only a word that did not bypass straight into the stage is buffered.
        push = accept && !(stage_free && level_q == '0);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);

        if (i_flush) begin
            vld_d    = '0;
            data_d   = '0;
            tgt_d    = '0;
            rr_d     = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            vld_q    <= '0;
            data_q   <= '0;
            tgt_q    <= '0;
            rr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            data_q   <= data_d;
            tgt_q    <= tgt_d;
            rr_q     <= rr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_rd_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_fifo_data;
    end

    assign o_lane_vld  = vld_q;
    assign o_lane_data = data_q;
    assign o_level     = level_q;

`ifdef RD_DISPATCH_PERF_EN
    logic [31:0] xfer_cnt_q, stall_cnt_q;

    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (i_flush) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer)                     xfer_cnt_q  <= xfer_cnt_q + 32'd1;
            if (vld_any && !i_lane_rdy[tgt_q]) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_xfer_cnt  = xfer_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_xfer_cnt  = 32'd0;
    assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rd_lane_dispatch.sv
// tb/tb_rd_lane_dispatch.sv - directed table-driven bench for rd_lane_dispatch
module tb_rd_lane_dispatch;
`ifdef RD_DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty, fifo_valid, fifo_rd_en;
    logic [7:0]  fifo_data;
    logic [1:0]  lane_vld, lane_rdy = 2'b00;
    logic [7:0]  lane_data;
    logic [2:0]  level;
    logic [31:0] xfer_cnt, stall_cnt;

    logic [7:0]  fifo_mem [64];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [7:0]  dq [$];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] rdy;
        logic [1:0] vld;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_rd == fifo_wr);
    assign fifo_valid = fifo_rd_en;
    assign fifo_data  = fifo_mem[fifo_rd[5:0]];

    always @(posedge clk) if (fifo_rd_en) fifo_rd <= fifo_rd + 1;

    // Delivery log: a word counts as delivered when its lane is ready.
    always @(negedge clk)
        if ((lane_vld & lane_rdy) != 2'b00) dq.push_back(lane_data);

    rd_lane_dispatch #(.WIDTH(8), .N_READERS(2), .BUF_DEPTH(4)) dut (
        .i_rd_clk(clk), .i_rd_rstn(rstn), .i_flush(flush),
        .i_fifo_empty(fifo_empty), .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data),
        .o_fifo_rd_en(fifo_rd_en), .o_lane_vld(lane_vld), .o_lane_data(lane_data),
        .i_lane_rdy(lane_rdy), .o_level(level),
        .o_xfer_cnt(xfer_cnt), .o_stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_mem[fifo_wr[5:0]] = w;
        fifo_wr++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, fr, s0, done;
        logic [7:0] exp_words [9];

        // Both-lanes-ready stream: alternates lane0/lane1 one word per cycle.
        for (int k = 0; k < 6; k++) tbl[k] = '{2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, 8'(k + 1)};
        tbl[6] = '{2'b11, 2'b00, 8'h06};
        // Lane0 never ready with RR at lane0: everything goes to lane1.
        for (int k = 0; k < 4; k++) tbl[7 + k] = '{2'b10, 2'b10, 8'(8'h11 + k)};
        tbl[11] = '{2'b10, 2'b00, 8'h14};

        // Reset state.
        #12;
        chk("rst_vld", 32'(lane_vld), 0);
        chk("rst_data", 32'(lane_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
        next_cycle();
        rstn = 1'b1;

        // Single word, bypass latency of one cycle.
        next_cycle();
        lane_rdy = 2'b01;
        push(8'hA5);
        @(negedge clk);
        chk("single_rd_en", 32'(fifo_rd_en), 1);
        chk("single_vld_t", 32'(lane_vld), 0);
        next_cycle();
        @(negedge clk);
        chk("single_vld", 32'(lane_vld), 32'b01);
        chk("single_data", 32'(lane_data), 32'hA5);
        chk("single_level", 32'(level), 0);
        next_cycle();
        @(negedge clk);
        chk("single_done", 32'(lane_vld), 0);

        // Flush returns the RR pointer to lane0 before the table runs.
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        chk("flush_xfer_clr", xfer_cnt, 0);

        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                lane_rdy = tbl[0].rdy;
                for (int w = 1; w <= 6; w++) push(8'(w));
            end
            if (k == 7) begin
                lane_rdy = tbl[7].rdy;
                for (int w = 0; w < 4; w++) push(8'(8'h11 + w));
            end
            next_cycle();
            lane_rdy = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_vld", k), 32'(lane_vld), 32'(tbl[k].vld));
            if (tbl[k].vld != 2'b00)
                chk($sformatf("tbl%0d_data", k), 32'(lane_data), 32'(tbl[k].data));
            chk($sformatf("tbl%0d_level", k), 32'(level), 0);
            if (k == 6) chk("stream_xfer_cnt", xfer_cnt, PERF ? 32'd6 : 32'd0);
        end

        // Back-pressure: nothing ready, buffer fills, held word stays put.
        next_cycle();
        lane_rdy = 2'b00;
        fr = fifo_rd;
        for (int w = 0; w < 8; w++) push(8'(8'h21 + w));
        repeat (8) next_cycle();
        @(negedge clk);
        chk("bp_level", 32'(level), 4);
        chk("bp_rd_en", 32'(fifo_rd_en), 0);
        chk("bp_vld", 32'(lane_vld), 32'b01);
        chk("bp_data", 32'(lane_data), 32'h21);
        chk("bp_popped", 32'(fifo_rd - fr), 5);
        s0 = stall_cnt;
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            chk("bp_vld_stable", 32'(lane_vld), 32'b01);
        end
        chk("bp_stall_delta", 32'(stall_cnt - s0), PERF ? 32'd3 : 32'd0);

        // Release one word, then flush with level 3 and valid set.
        next_cycle();
        lane_rdy = 2'b01;
        next_cycle();
        lane_rdy = 2'b00;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_pre_level", 32'(level), 3);
        chk("fl_pre_vld", 32'(lane_vld), 32'b01);
        chk("fl_pre_data", 32'(lane_data), 32'h22);
        chk("fl_no_pop", 32'(fifo_rd_en), 0);
        fr = fifo_rd;
        next_cycle();
        flush = 1'b0;
        lane_rdy = 2'b11;
        @(negedge clk);
        chk("fl_level", 32'(level), 0);
        chk("fl_vld", 32'(lane_vld), 0);
        chk("fl_popped", 32'(fifo_rd - fr), 0);
        chk("fl_xfer", xfer_cnt, 0);
        chk("fl_stall", stall_cnt, 0);
        next_cycle();
        @(negedge clk);
        chk("fl_rr0_vld", 32'(lane_vld), 32'b01);
        chk("fl_rr0_data", 32'(lane_data), 32'h26);
        next_cycle();
        @(negedge clk);
        chk("fl_rr1_vld", 32'(lane_vld), 32'b10);
        chk("fl_rr1_data", 32'(lane_data), 32'h27);
        repeat (3) next_cycle();

        // Asynchronous reset mid-stream; 0x33 is in the stage and is lost.
        mark = dq.size();
        for (int w = 0; w < 10; w++) push(8'(8'h31 + w));
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("ar_vld", 32'(lane_vld), 0);
        chk("ar_data", 32'(lane_data), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_rd_en", 32'(fifo_rd_en), 0);
        chk("ar_xfer", xfer_cnt, 0);
        chk("ar_stall", stall_cnt, 0);
        next_cycle();
        rstn = 1'b1;
        done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fifo_empty && lane_vld == 2'b00) begin
                done = 1;
                break;
            end
        end
        chk("ar_drain_done", 32'(done), 1);
        exp_words[0] = 8'h31;
        exp_words[1] = 8'h32;
        for (int w = 0; w < 7; w++) exp_words[2 + w] = 8'(8'h34 + w);
        chk("ar_count", 32'(dq.size() - mark), 9);
        for (int w = 0; w < 9; w++)
            if (mark + w < dq.size())
                chk($sformatf("ar_word%0d", w), 32'(dq[mark + w]), 32'(exp_words[w]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
